// File: rtl/shift_reg_pair.sv
// shift_reg_pair: double-width {hi,lo} shift register running SLL/SRL/SRA/ROR one bit per clock
//   clk, reset        : clock, synchronous active-high reset
//   load, hi_in, lo_in: parallel load of {hi,lo}, honoured in IDLE only (wins over start)
//   start, op, amount : launch a shift of amount bits; op 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   hi_out, lo_out    : current {hi,lo}
//   busy, done        : busy while shifting, done pulses one cycle with the final value
//   Optional FAST_SHIFT_EN: two bits per step while at least two remain.
module shift_reg_pair #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(2*WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   hi_in,
  input  logic [WIDTH-1:0]   lo_in,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] amount,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output logic               busy,
  output logic               done
);
  localparam int W2 = 2*WIDTH;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [W2-1:0] v_q, v_d, step1, step;
  logic [1:0] op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d, dec;
  always_comb step1 = op_q == OP_SLL ? {v_q[W2-2:0], 1'b0} :
                      op_q == OP_SRL ? {1'b0, v_q[W2-1:1]} :
                      op_q == OP_SRA ? {v_q[W2-1], v_q[W2-1:1]} :
                                       {v_q[0], v_q[W2-1:1]};
`ifdef FAST_SHIFT_EN
  logic [W2-1:0] step2;
  logic two;
  always_comb begin
    step2 = op_q == OP_SLL ? {v_q[W2-3:0], 2'b00} :
            op_q == OP_SRL ? {2'b00, v_q[W2-1:2]} :
            op_q == OP_SRA ? {{2{v_q[W2-1]}}, v_q[W2-1:2]} :
                             {v_q[1:0], v_q[W2-1:2]};
    two = cnt_q > ONE;
    step = two ? step2 : step1;
    dec = two ? SHAMT_W'(2) : ONE;
  end
`else
  always_comb begin
    step = step1;
    dec = ONE;
  end
`endif
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    op_d = op_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (load) v_d = {hi_in, lo_in};
      else if (start) begin
        op_d = op;
        cnt_d = amount;
        state_d = amount == '0 ? DONE : SHIFT;
      end
    end else if (state_q == SHIFT) begin
      v_d = step;
      cnt_d = cnt_q - dec;
      state_d = cnt_q == dec ? DONE : SHIFT;
    end else state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      v_q <= '0;
      op_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
    end
  end
  assign hi_out = v_q[W2-1:WIDTH];
  assign lo_out = v_q[WIDTH-1:0];
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_shift_reg_pair.sv
// tb_shift_reg_pair: scoreboard bench for shift_reg_pair at WIDTH=32
module tb_shift_reg_pair;
  logic clk = 0, reset = 1, load = 0, start = 0;
  logic [31:0] hi_in = 0, lo_in = 0, hi_out, lo_out;
  logic [1:0] op = 0;
  logic [5:0] amount = 0;
  logic busy, done;
  int total = 0, bad = 0, bcnt = 0;
  typedef struct {logic [31:0] hi; logic [31:0] lo; int cyc;} exp_t;
  exp_t q[$];
  shift_reg_pair #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .load(load), .hi_in(hi_in), .lo_in(lo_in),
    .start(start), .op(op), .amount(amount), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) bcnt = 0;
    else if (busy) bcnt++;
    if (done && !reset) begin
      if (q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("result", {hi_out, lo_out}, {e.hi, e.lo});
        chk("busy_cycles", 64'(bcnt), 64'(e.cyc));
      end
      bcnt = 0;
    end
  end
  task automatic do_load(input logic [31:0] h, input logic [31:0] l);
    @(posedge clk); #1 load = 1; hi_in = h; lo_in = l;
    @(posedge clk); #1 load = 0;
    chk("load", {hi_out, lo_out}, {h, l});
  endtask
  task automatic do_shift(input logic [1:0] o, input int n, input logic [31:0] eh,
                          input logic [31:0] el, input bit disturb);
    bit seen;
    q.push_back('{eh, el, n});
    @(posedge clk); #1 start = 1; op = o; amount = n[5:0];
    @(posedge clk); #1 start = 0; op = ~o; amount = ~amount;
    if (disturb) begin
      @(posedge clk); #1 load = 1; start = 1; hi_in = '1; lo_in = '1;
      @(posedge clk);
      @(posedge clk); #1 load = 0; start = 0;
    end
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask
  initial begin
    @(posedge clk); #1;
    chk("reset_state", {hi_out, lo_out, 30'd0, busy, done}, 96'd0);
    reset = 0;
    do_load(32'h0000_0001, 32'h8000_0000);
    do_shift(2'b00, 1, 32'h0000_0003, 32'h0000_0000, 0);
    do_load(32'h8000_0000, 32'h0);
    do_shift(2'b10, 63, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_load(32'h0, 32'h0000_0001);
    do_shift(2'b11, 1, 32'h8000_0000, 32'h0, 0);
    do_shift(2'b01, 0, 32'h8000_0000, 32'h0, 0);
    do_load(32'h0000_00FF, 32'h0);
    do_shift(2'b01, 5, 32'h0000_0007, 32'hF800_0000, 0);
    do_load(32'h4000_0000, 32'h0);
    do_shift(2'b10, 62, 32'h0, 32'h1, 0);
    do_load(32'h0, 32'h0000_000F);
    do_shift(2'b11, 36, 32'h0, 32'hF000_0000, 0);
    do_load(32'hF0F0_F0F0, 32'h0F0F_0F0F);
    do_shift(2'b00, 8, 32'hF0F0_F00F, 32'h0F0F_0F00, 1);
    begin
      bit quiet;
      @(posedge clk); #1 load = 1; start = 1; op = 2'b11; amount = 6'd4;
      hi_in = 32'h1234_5678; lo_in = 32'h9ABC_DEF0;
      @(posedge clk); #1 load = 0; start = 0;
      quiet = 1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (busy || done || {hi_out, lo_out} !== 64'h1234_5678_9ABC_DEF0) quiet = 0;
      end
      chk("load_beats_start", {63'd0, quiet}, 64'd1);
    end
    do_load(32'hFFFF_FFFF, 32'h1);
    q.push_back('{32'h0, 32'h0, 0});
    @(posedge clk); #1 start = 1; op = 2'b00; amount = 6'd20;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    q.delete();
    chk("reset_mid_shift", {hi_out, lo_out, 30'd0, busy, done}, 96'd0);
    begin
      bit nodone;
      nodone = 1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done || busy) nodone = 0;
      end
      chk("no_done_after_reset", {63'd0, nodone}, 64'd1);
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
